fpu_normalizer: RTL and testbench

- Iterative normalizer for the BKM FPU datapath; the inverse companion of barrel_shifter.
- Takes a W-bit operand and finds the left-shift amount that normalizes it:
  - unsigned mode: leading zeros, so MSB=1.
  - signed mode: redundant sign bits, so bit W-1 != bit W-2.
- Returns the normalized word plus the shift count. The count is directly usable as barrel_shifter sel, with dir=right, for later denormalization.
- Binary-search algorithm, one stage per cycle, behind valid/ready handshakes on both sides.

---
 rtl/fpu_normalizer_if.sv | 30 +++
 rtl/fpu_normalizer.sv | 134 +++++++++++++
 tb/tb_fpu_normalizer.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_normalizer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fpu_normalizer_if : operand/result handshake bundle for normalizer |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface fpu_normalizer_if #(
  parameter int W     = 8,
  parameter int LOG2W = 3
) ();
  logic             in_valid;
  logic             in_ready;
  logic             in_mode;
  logic [W-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_data;
  logic [LOG2W-1:0] out_cnt;
  logic             out_zero;

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_data, out_cnt, out_zero
  );

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_cnt, out_zero
  );
endinterface
`default_nettype wire

// File: rtl/fpu_normalizer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fpu_normalizer : iterative binary-search normalizer (lz / sign)    |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module fpu_normalizer #(
  parameter int W     = 8,
  parameter int LOG2W = 3
) (
  input  wire logic        clk,
  input  wire logic        rst,
  fpu_normalizer_if.slave  bus
);

  localparam int SW = LOG2W + 1;
  localparam logic [SW-1:0]    C_SPAN_ONE = SW'(1);
  localparam logic [LOG2W-1:0] C_CNT_ONE  = LOG2W'(1);
  localparam logic [LOG2W-1:0] C_LAST     = LOG2W'(LOG2W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_in_ready;
  logic             w_out_valid;

  logic [W-1:0]     r_work;
  logic             r_mode;
  logic [LOG2W-1:0] r_step;
  logic [LOG2W-1:0] r_cnt;
  logic             r_zero;
  logic [W-1:0]     r_out_data;
  logic [LOG2W-1:0] r_out_cnt;
  logic             r_out_zero;

  logic [SW-1:0]    w_span;
  logic [W-1:0]     w_mask_u;
  logic [W-1:0]     w_mask_s;
  logic [W-1:0]     w_top_u;
  logic [W-1:0]     w_top_s;
  logic             w_take;
  logic [W-1:0]     w_work_nx;
  logic [LOG2W-1:0] w_cnt_nx;
  logic             w_in_zero;

  // Stage k tests the top 2^k bits (unsigned) or top 2^k+1 bits (signed).
  always_comb begin
    w_span    = C_SPAN_ONE << r_step;
    w_mask_u  = ~({W{1'b1}} >> w_span);
    w_mask_s  = ~({W{1'b1}} >> (w_span + C_SPAN_ONE));
    w_top_u   = r_work & w_mask_u;
    w_top_s   = r_work & w_mask_s;
    w_take    = r_mode ? ((w_top_s == '0) || (w_top_s == w_mask_s))
                       : (w_top_u == '0);
    w_work_nx = w_take ? (r_work << w_span) : r_work;
    w_cnt_nx  = r_cnt | (w_take ? (C_CNT_ONE << r_step) : '0);
    w_in_zero = bus.in_mode ? ((bus.in_data == '0) || (bus.in_data == '1))
                            : (bus.in_data == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_next = S_RUN;
      end
      S_RUN: begin
        if (r_step == '0) w_next = S_DONE;
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_work     <= '0;
      r_mode     <= 1'b0;
      r_step     <= '0;
      r_cnt      <= '0;
      r_zero     <= 1'b0;
      r_out_data <= '0;
      r_out_cnt  <= '0;
      r_out_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_work <= bus.in_data;
            r_mode <= bus.in_mode;
            r_cnt  <= '0;
            r_step <= C_LAST;
            r_zero <= w_in_zero;
          end
        end
        S_RUN: begin
          r_work <= w_work_nx;
          r_cnt  <= w_cnt_nx;
          r_step <= r_step - C_CNT_ONE;
          // Result registers only move on the final stage so they hold between operands.
          if (r_step == '0) begin
            r_out_data <= w_work_nx;
            r_out_cnt  <= w_cnt_nx;
            r_out_zero <= r_zero;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_cnt   = r_out_cnt;
  assign bus.out_zero  = r_out_zero;

endmodule
`default_nettype wire

// File: tb/tb_fpu_normalizer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fpu_normalizer : randomized bench with behavioural model        |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_fpu_normalizer;
  localparam int W     = 8;
  localparam int LOG2W = 3;

  logic clk = 1'b0;
  logic rst;

  fpu_normalizer_if #(.W(W), .LOG2W(LOG2W)) nif ();
  fpu_normalizer #(.W(W), .LOG2W(LOG2W)) dut (.clk(clk), .rst(rst), .bus(nif));

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]     din;
    logic             mode;
    logic [W-1:0]     data;
    logic [LOG2W-1:0] cnt;
    logic             zero;
    int               t;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  bit   fresh = 1'b1;
  bit   done  = 1'b0;

  // Shift one place at a time while the top bit is not yet significant.
  function automatic exp_t model(input logic [W-1:0] d, input logic m);
    exp_t         e;
    int           n = 0;
    logic [W-1:0] x = d;
    if (m) begin
      while (n < W-1 && x[W-1] == x[W-2]) begin x = {x[W-2:0], 1'b0}; n++; end
    end else begin
      while (n < W-1 && !x[W-1]) begin x = {x[W-2:0], 1'b0}; n++; end
    end
    e.din  = d;
    e.mode = m;
    e.data = x;
    e.cnt  = LOG2W'(n);
    e.zero = m ? (d == '0 || d == '1) : (d == '0);
    e.t    = 0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  always begin : mon
    exp_t         e;
    logic [W-1:0] back;
    @(posedge clk);
    cyc++;
    if (rst) begin
      q.delete();
      fresh = 1'b1;
    end else begin
      if (nif.out_valid && nif.out_ready && q.size() > 0) begin
        void'(q.pop_front());
        fresh = 1'b1;
      end
      if (nif.in_valid && nif.in_ready) begin
        e   = model(nif.in_data, nif.in_mode);
        e.t = cyc;
        q.push_back(e);
      end
    end
    @(negedge clk);
    if (nif.out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = q[0];
        if (fresh) begin
          chk("latency", cyc - e.t, LOG2W);
          fresh = 1'b0;
        end
        chk("out_data", nif.out_data, e.data);
        chk("out_cnt", nif.out_cnt, e.cnt);
        chk("out_zero", nif.out_zero, e.zero);
        chk("in_ready_busy", nif.in_ready, 0);
        back = e.mode ? W'($signed(nif.out_data) >>> nif.out_cnt) : (nif.out_data >> nif.out_cnt);
        chk("roundtrip", back, e.din);
        if (!nif.out_zero)
          chk("invariant", e.mode ? (nif.out_data[W-1] ^ nif.out_data[W-2]) : nif.out_data[W-1], 1);
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input logic m);
    bit acc = 1'b0;
    int k   = 0;
    @(negedge clk);
    nif.in_valid = 1'b1;
    nif.in_data  = d;
    nif.in_mode  = m;
    while (!acc && k < 200) begin
      @(posedge clk);
      acc = nif.in_ready;
      k++;
    end
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    nif.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((q.size() != 0 || nif.out_valid) && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (k >= 500) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  logic [W-1:0] dd [6] = '{8'h13, 8'hF3, 8'h01, 8'h00, 8'hFF, 8'h80};
  bit           mm [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin : main
    exp_t e;
    int   k;
    rst           = 1'b1;
    nif.in_valid  = 1'b0;
    nif.in_data   = '0;
    nif.in_mode   = 1'b0;
    nif.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", nif.in_ready, 1);
    chk("rst_out_valid", nif.out_valid, 0);
    chk("rst_out_data", nif.out_data, 0);
    chk("rst_out_cnt", nif.out_cnt, 0);
    chk("rst_out_zero", nif.out_zero, 0);
    rst = 1'b0;

    e = model(8'h13, 1'b0); chk("pin_13u_data", e.data, 8'h98); chk("pin_13u_cnt", e.cnt, 3); chk("pin_13u_zero", e.zero, 0);
    e = model(8'hF3, 1'b1); chk("pin_F3s_data", e.data, 8'h98); chk("pin_F3s_cnt", e.cnt, 3);
    e = model(8'h01, 1'b1); chk("pin_01s_data", e.data, 8'h40); chk("pin_01s_cnt", e.cnt, 6);
    e = model(8'h00, 1'b0); chk("pin_00u_data", e.data, 8'h00); chk("pin_00u_cnt", e.cnt, 7); chk("pin_00u_zero", e.zero, 1);
    e = model(8'hFF, 1'b1); chk("pin_FFs_data", e.data, 8'h80); chk("pin_FFs_cnt", e.cnt, 7); chk("pin_FFs_zero", e.zero, 1);
    e = model(8'h80, 1'b0); chk("pin_80u_data", e.data, 8'h80); chk("pin_80u_cnt", e.cnt, 0); chk("pin_80u_zero", e.zero, 0);

    nif.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(dd[i], mm[i]);
      wait_idle();
    end

    // Backpressure: result must hold and no operand may slip in.
    nif.out_ready = 1'b0;
    send(8'h13, 1'b0);
    k = 0;
    while (!nif.out_valid && k < 20) begin @(negedge clk); k++; end
    chk("bp_valid_seen", nif.out_valid, 1);
    repeat (5) begin
      @(negedge clk);
      nif.in_valid = 1'($urandom_range(0, 1));
      nif.in_data  = W'($urandom);
      nif.in_mode  = 1'($urandom_range(0, 1));
      chk("bp_in_ready", nif.in_ready, 0);
      chk("bp_out_valid", nif.out_valid, 1);
    end
    @(negedge clk);
    nif.out_ready = 1'b1;
    nif.in_valid  = 1'b1;
    nif.in_data   = 8'h80;
    nif.in_mode   = 1'b0;
    @(negedge clk);
    chk("hs_in_ready", nif.in_ready, 1);
    chk("hs_out_valid", nif.out_valid, 0);
    @(negedge clk);
    nif.in_valid = 1'b0;
    chk("hs_accepted", nif.in_ready, 0);
    wait_idle();

    // Reset one cycle after accept.
    send(8'h13, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", nif.in_ready, 1);
    chk("mid_rst_out_valid", nif.out_valid, 0);
    chk("mid_rst_out_cnt", nif.out_cnt, 0);
    rst = 1'b0;
    send(8'h40, 1'b0);
    wait_idle();

    fork
      begin
        repeat (1000) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          send(W'($urandom), 1'($urandom_range(0, 1)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          nif.out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    nif.out_ready = 1'b1;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
